stage_if_fetch: RTL

Instruction-fetch stage directly upstream of the decode stage. It holds the PC and issues one outstanding request at a time to the instruction cache over a valid/ready handshake. It buffers a response that cannot yet advance, and drives the IF/ID pipeline outputs (pc, inst) consumed by decode. It obeys hazard-unit stall signals (IF_ID_Write, PC_Write), the dcache stall, and branch/jump redirects from EX.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/if_id_reg.sv | 20 ++
 rtl/stage_if_fetch.sv | 80 ++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch FSM states, IF/ID payload and pipeline constants
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with bubble (priority), load and hold
module if_id_reg #(
  parameter logic [pipeline_pkg::XLEN-1:0] NOP_INST = pipeline_pkg::NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 bubble_i,
  input  pipeline_pkg::if_id_t d_i,
  output pipeline_pkg::if_id_t q_o
);
  import pipeline_pkg::*;
  if_id_t q_q;
  // bubble keeps the supplied pc but forces a NOP and clears valid; otherwise load or hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    else if (bubble_i) q_q <= '{pc: d_i.pc, inst: NOP_INST, valid: 1'b0};
    else if (load_i) q_q <= d_i;
  assign q_o = q_q;
endmodule

// File: rtl/stage_if_fetch.sv
// stage_if_fetch: PC, single-outstanding icache fetch FSM and fetch buffer feeding IF/ID
module stage_if_fetch #(
  parameter int                XLEN     = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = pipeline_pkg::RESET_PC,
  parameter logic [XLEN-1:0]   NOP_INST = pipeline_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IF_ID_Write,
  input  logic            PC_Write,
  input  logic            dcache_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            icache_req_valid,
  output logic [XLEN-1:0] icache_req_addr,
  input  logic            icache_req_ready,
  input  logic            icache_resp_valid,
  input  logic [XLEN-1:0] icache_resp_data,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic            icache_stall
);
  import pipeline_pkg::*;
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, fb_inst_q, fb_inst_d, fb_pc_q, fb_pc_d;
  logic            advance, has_inst, ld, bub, cap;
  if_id_t          ifid_d, ifid_q;
  // an instruction is available from the live response in S_WAIT or from the buffer in S_HOLD;
  // a redirect flushes IF/ID regardless of stalls and realigns the PC
  always_comb begin
    advance      = IF_ID_Write & PC_Write & ~dcache_stall;
    has_inst     = (state_q == S_WAIT & icache_resp_valid) | state_q == S_HOLD;
    ld           = ~redirect_valid & advance & has_inst;
    bub          = redirect_valid | (advance & ~has_inst);
    cap          = ~redirect_valid & ~advance & state_q == S_WAIT & icache_resp_valid;
    icache_stall = advance & ~redirect_valid & ~has_inst;
    ifid_d.pc    = redirect_valid ? redirect_pc : state_q == S_HOLD ? fb_pc_q : pc_q;
    ifid_d.inst  = state_q == S_HOLD ? fb_inst_q : icache_resp_data;
    ifid_d.valid = 1'b1;
    pc_d         = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : ld ? pc_q + XLEN'(4) : pc_q;
    fb_inst_d    = redirect_valid ? '0 : cap ? icache_resp_data : fb_inst_q;
    fb_pc_d      = redirect_valid ? '0 : cap ? pc_q : fb_pc_q;
    state_d      = state_q;
    case (state_q)
      S_REQ:   state_d = icache_req_ready ? (redirect_valid ? S_KILL : S_WAIT) : S_REQ;
      S_WAIT:  state_d = icache_resp_valid ? (redirect_valid | advance ? S_REQ : S_HOLD)
                                           : (redirect_valid ? S_KILL : S_WAIT);
      S_HOLD:  state_d = redirect_valid | advance ? S_REQ : S_HOLD;
      S_KILL:  state_d = icache_resp_valid ? S_REQ : S_KILL;
      default: state_d = S_REQ;
    endcase
  end
  // fetch FSM, PC and fetch buffer state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      fb_inst_q <= '0;
      fb_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fb_inst_q <= fb_inst_d;
      fb_pc_q   <= fb_pc_d;
    end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (ld),
    .bubble_i (bub),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );
  assign icache_req_valid = state_q == S_REQ;
  assign icache_req_addr  = pc_q;
  assign pc_out           = ifid_q.pc;
  assign inst             = ifid_q.inst;
  assign inst_valid       = ifid_q.valid;
endmodule
